// File: rtl/gpu_rasterizer.sv
// gpu_rasterizer: consumer end of the CPU->GPU draw-op FIFO.
// Pops one gpu_op_t at a time and draws it into the back framebuffer at one
// pixel per ce cycle, either as a solid-colour rectangle fill or as a sprite
// blit from the sprite ROM (optionally 2x upscaled).
// Optional feature macro: GPU_SPRITE_TRANSPARENCY_EN -- when defined, sprite
// texels whose opaque bit (sprite_data[1]) is clear are not written.

package gpu_rasterizer_pkg;
  localparam int GPU_SPRITE_AW = 16;

  typedef struct packed {
    logic [9:0]               x;
    logic [9:0]               y;
    logic [9:0]               width;
    logic [9:0]               height;
    logic                     color;
    logic                     mem_en;
    logic [GPU_SPRITE_AW-1:0] mem_addr;
    logic                     scale;
  } gpu_op_t;
endpackage

module gpu_rasterizer
  import gpu_rasterizer_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int SPRITE_ADDR_WIDTH = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                ce,
  input  gpu_op_t                                             op,
  output logic                                                op_rd_en,
  input  logic                                                op_empty,
  output logic [SPRITE_ADDR_WIDTH-1:0]                        sprite_addr,
  input  logic [1:0]                                          sprite_data,
  output logic                                                fb_wr_en,
  output logic [$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)-1:0] fb_addr,
  output logic                                                fb_data,
  output logic                                                idle
);

  localparam int FB_AW = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_FILL,
    S_BLIT,
    S_FLUSH
  } state_t;

  state_t state_reg, state_next;

  // Latched op and raster counters
  gpu_op_t    op_reg;
  logic [9:0] col_reg;
  logic [9:0] row_reg;

  // Registered outputs
  logic                         op_rd_en_reg;
  logic                         fb_wr_en_reg;
  logic [FB_AW-1:0]             fb_addr_reg;
  logic                         fb_data_reg;
  logic [SPRITE_ADDR_WIDTH-1:0] sprite_addr_reg;

  // Blit pipeline: pixel position travels one cycle behind its ROM address
  logic             pipe_valid_reg;
  logic [FB_AW-1:0] pipe_addr_reg;
  // High when the visible write is a sprite texel, so data comes from the ROM
  logic             blit_wr_reg;

  // Datapath helpers
  logic [11:0]                  px, py;
  logic                         in_bounds;
  logic [23:0]                  pix_lin;
  logic [FB_AW-1:0]             pix_addr;
  logic                         last_col, last_pix;
  logic [9:0]                   tc, tr, stride;
  logic [10:0]                  width_ext;
  logic [19:0]                  tex_off;
  logic [SPRITE_ADDR_WIDTH-1:0] sprite_next;
  logic                         latch_empty_op;

  // Pixel coordinates, clipping and linear address of the current pixel
  always_comb begin
    px        = 12'(op_reg.x) + 12'(col_reg);
    py        = 12'(op_reg.y) + 12'(row_reg);
    in_bounds = (px < 12'(HOR_ACTIVE_PIXELS)) && (py < 12'(VER_ACTIVE_PIXELS));
    pix_lin   = 24'(py) * 24'(HOR_ACTIVE_PIXELS) + 24'(px);
    pix_addr  = pix_lin[FB_AW-1:0];
    last_col  = (col_reg == op_reg.width - 10'd1);
    last_pix  = last_col && (row_reg == op_reg.height - 10'd1);
  end

  // Texel address: upscaled sprites read each texel for a 2x2 pixel block
  always_comb begin
    width_ext = {1'b0, op_reg.width};
    if (op_reg.scale) begin
      tc     = col_reg >> 1;
      tr     = row_reg >> 1;
      stride = 10'((width_ext + 11'd1) >> 1);
    end else begin
      tc     = col_reg;
      tr     = row_reg;
      stride = op_reg.width;
    end
    tex_off     = 20'(tr) * 20'(stride) + 20'(tc);
    sprite_next = SPRITE_ADDR_WIDTH'(op_reg.mem_addr) + SPRITE_ADDR_WIDTH'(tex_off);
  end

  assign latch_empty_op = (op.width == 10'd0) || (op.height == 10'd0);

  // State register; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else if (ce) begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (!op_empty) state_next = S_POP;
      S_POP:   state_next = S_LATCH;
      S_LATCH: begin
        if (latch_empty_op)   state_next = S_IDLE;
        else if (op.mem_en)   state_next = S_BLIT;
        else                  state_next = S_FILL;
      end
      S_FILL:  if (last_pix) state_next = S_IDLE;
      S_BLIT:  if (last_pix) state_next = S_FLUSH;
      S_FLUSH: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: op latch, raster counters, pop strobe, pixel writes, ROM address
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg          <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      op_rd_en_reg    <= 1'b0;
      fb_wr_en_reg    <= 1'b0;
      fb_addr_reg     <= '0;
      fb_data_reg     <= 1'b0;
      sprite_addr_reg <= '0;
      pipe_valid_reg  <= 1'b0;
      pipe_addr_reg   <= '0;
      blit_wr_reg     <= 1'b0;
    end else if (ce) begin
      op_rd_en_reg   <= 1'b0;
      fb_wr_en_reg   <= 1'b0;
      pipe_valid_reg <= 1'b0;
      blit_wr_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          op_rd_en_reg <= !op_empty;
        end
        S_LATCH: begin
          op_reg  <= op;
          col_reg <= '0;
          row_reg <= '0;
        end
        S_FILL: begin
          fb_wr_en_reg <= in_bounds;
          fb_addr_reg  <= pix_addr;
          fb_data_reg  <= op_reg.color;
          if (last_col) begin
            col_reg <= '0;
            row_reg <= row_reg + 10'd1;
          end else begin
            col_reg <= col_reg + 10'd1;
          end
        end
        S_BLIT: begin
          // Stage 1: issue ROM address for this pixel
          sprite_addr_reg <= sprite_next;
          pipe_valid_reg  <= in_bounds;
          pipe_addr_reg   <= pix_addr;
          // Stage 2: write the previous pixel once its texel arrives
          fb_wr_en_reg    <= pipe_valid_reg;
          fb_addr_reg     <= pipe_addr_reg;
          blit_wr_reg     <= 1'b1;
          if (last_col) begin
            col_reg <= '0;
            row_reg <= row_reg + 10'd1;
          end else begin
            col_reg <= col_reg + 10'd1;
          end
        end
        S_FLUSH: begin
          fb_wr_en_reg <= pipe_valid_reg;
          fb_addr_reg  <= pipe_addr_reg;
          blit_wr_reg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign op_rd_en    = op_rd_en_reg;
  assign sprite_addr = sprite_addr_reg;
  assign fb_addr     = fb_addr_reg;
  // Texel colour arrives from the ROM in the same cycle as its write strobe
  assign fb_data     = blit_wr_reg ? sprite_data[0] : fb_data_reg;
  assign idle        = (state_reg == S_IDLE) && op_empty;

`ifdef GPU_SPRITE_TRANSPARENCY_EN
  assign fb_wr_en = fb_wr_en_reg && (!blit_wr_reg || sprite_data[1]);
`else
  logic unused_opaque;
  assign unused_opaque = sprite_data[1];
  assign fb_wr_en      = fb_wr_en_reg;
`endif

endmodule

// File: tb/tb_gpu_rasterizer.sv
// Testbench for gpu_rasterizer: FIFO and sprite ROM models, a reference model
// that expands each op into its expected pixel writes, and a per-cycle monitor.
module tb_gpu_rasterizer;
  import gpu_rasterizer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  gpu_op_t     op;
  logic        op_rd_en;
  logic        op_empty;
  logic [15:0] sprite_addr;
  logic [1:0]  sprite_data;
  logic        fb_wr_en;
  logic [18:0] fb_addr;
  logic        fb_data;
  logic        idle;

  gpu_rasterizer #(
    .HOR_ACTIVE_PIXELS(640),
    .VER_ACTIVE_PIXELS(480),
    .SPRITE_ADDR_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .op(op), .op_rd_en(op_rd_en),
    .op_empty(op_empty), .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .fb_wr_en(fb_wr_en), .fb_addr(fb_addr), .fb_data(fb_data), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit data; } wr_t;

  gpu_op_t fifo[$];
  wr_t     exp_wr[$];
  int      nvec  = 0;
  int      nfail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Sprite ROM contents
  function automatic logic [1:0] rom_fn(int a);
    return {a[6] | a[3], a[0] ^ a[2]};
  endfunction

  function automatic gpu_op_t mk_op(int x, int y, int w, int h, bit color,
                                    bit mem_en, int mem_addr, bit scale);
    gpu_op_t o;
    o.x = 10'(x); o.y = 10'(y); o.width = 10'(w); o.height = 10'(h);
    o.color = color; o.mem_en = mem_en; o.mem_addr = 16'(mem_addr); o.scale = scale;
    return o;
  endfunction

  // Reference model: raster-order list of the pixels the op must write
  task automatic model_op(gpu_op_t o);
    int w, h, px, py, off, ta;
    logic [1:0] tex;
    bit opaque;
    w = int'(o.width);
    h = int'(o.height);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = int'(o.x) + c;
        py = int'(o.y) + r;
        if (px < 640 && py < 480) begin
          if (o.mem_en) begin
            if (o.scale) off = (r / 2) * ((w + 1) / 2) + c / 2;
            else         off = r * w + c;
            ta  = (int'(o.mem_addr) + off) % 65536;
            tex = rom_fn(ta);
`ifdef GPU_SPRITE_TRANSPARENCY_EN
            opaque = tex[1];
`else
            opaque = 1'b1;
`endif
            if (opaque) exp_wr.push_back('{py * 640 + px, tex[0]});
          end else begin
            exp_wr.push_back('{py * 640 + px, o.color});
          end
        end
      end
    end
  endtask

  // Per-cycle monitor state
  int          cyc = 0, pops = 0, wr_count = 0;
  int          last_pop_cyc = -100, first_wr_cyc = 0, idle_rise_cyc = 0;
  logic [18:0] first_wr_addr;
  bit          first_wr_seen = 1'b0;
  bit          idle_prev = 1'b1;
  logic        s_ce = 1'b1, s_rst = 1'b1, s_rd = 1'b0;
  logic [15:0] s_sa = '0;
  logic [37:0] snap_prev = '0;
  logic [15:0] sa_log [8];

  // Compare process: checks writes against the model and hold-on-ce-low
  always @(negedge clk) begin
    logic [37:0] snap;
    wr_t e;
    int  d;
    cyc++;
    snap = {op_rd_en, fb_wr_en, fb_addr, fb_data, sprite_addr};
    if (!s_ce && !s_rst) check("hold_on_ce_low", 64'(snap), 64'(snap_prev));
    snap_prev = snap;
    if (!rst) check("rd_en_while_empty", 64'(op_rd_en & op_empty), 64'(0));
    if (ce && op_rd_en) begin
      pops++;
      last_pop_cyc  = cyc;
      first_wr_seen = 1'b0;
    end
    if (ce && fb_wr_en) begin
      wr_count++;
      if (!first_wr_seen) begin
        first_wr_seen = 1'b1;
        first_wr_cyc  = cyc;
        first_wr_addr = fb_addr;
      end
      if (exp_wr.size() == 0) begin
        check("unexpected_write_addr", 64'(fb_addr), 64'hFFFF_FFFF);
      end else begin
        e = exp_wr.pop_front();
        check("write_addr", 64'(fb_addr), 64'(e.addr));
        check("write_data", 64'(fb_data), 64'(e.data));
      end
    end
    d = cyc - last_pop_cyc;
    if (d >= 3 && d <= 10) sa_log[d-3] = sprite_addr;
    if (idle && !idle_prev) idle_rise_cyc = cyc;
    idle_prev = idle;
    s_ce  = ce;
    s_rst = rst;
    s_rd  = op_rd_en;
    s_sa  = sprite_addr;
  end

  // FIFO and ROM models, advanced on ce cycles just after the clock edge
  always @(posedge clk) begin
    #1;
    if (s_ce) begin
      if (!s_rst && s_rd && fifo.size() > 0) begin
        op       = fifo.pop_front();
        op_empty = (fifo.size() == 0);
      end
      sprite_data = rom_fn(int'(s_sa));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(gpu_op_t o);
    fifo.push_back(o);
    op_empty = 1'b0;
    model_op(o);
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < budget);
    tick();
    check({tag, "_timeout"}, 64'(n >= budget), 64'(0));
    check({tag, "_missing_writes"}, 64'(exp_wr.size()), 64'(0));
    $display("op %s done: cycles=%0d writes_total=%0d pops_total=%0d", tag, n, wr_count, pops);
  endtask

  initial begin
    int w0, p0;
    int exp_sa [8] = '{100, 100, 101, 101, 100, 100, 101, 101};

    rst = 1'b1; ce = 1'b1; op_empty = 1'b1; op = '0; sprite_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_op_rd_en", 64'(op_rd_en), 64'(0));
    check("rst_fb_wr_en", 64'(fb_wr_en), 64'(0));
    check("rst_fb_addr", 64'(fb_addr), 64'(0));
    check("rst_fb_data", 64'(fb_data), 64'(0));
    check("rst_sprite_addr", 64'(sprite_addr), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    tick();

    // Fill 3x2 at (10,5): 6 writes starting at 5*640+10
    w0 = wr_count;
    push_op(mk_op(10, 5, 3, 2, 1'b1, 1'b0, 0, 1'b0));
    wait_done("fill", 200);
    check("fill_writes", 64'(wr_count - w0), 64'(6));
    check("fill_first_addr", 64'(first_wr_addr), 64'(3210));
    check("fill_first_wr_latency", 64'(first_wr_cyc - last_pop_cyc), 64'(3));
    // idle rises 9 cycles after the pop decision, i.e. 8 after op_rd_en
    check("fill_idle_latency", 64'(idle_rise_cyc - last_pop_cyc), 64'(8));

    // Clipped fill: only (638,479) and (639,479) land on screen
    w0 = wr_count;
    push_op(mk_op(638, 479, 4, 3, 1'b1, 1'b0, 0, 1'b0));
    wait_done("clip", 200);
    check("clip_writes", 64'(wr_count - w0), 64'(2));
    check("clip_first_addr", 64'(first_wr_addr), 64'(307198));
    check("clip_idle_latency", 64'(idle_rise_cyc - last_pop_cyc), 64'(14));

    // Upscaled sprite 4x2 from ROM address 100
    w0 = wr_count;
    push_op(mk_op(0, 0, 4, 2, 1'b0, 1'b1, 100, 1'b1));
    wait_done("sprite", 200);
    for (int i = 0; i < 8; i++) check("sprite_rom_addr", 64'(sa_log[i]), 64'(exp_sa[i]));
    check("sprite_writes", 64'(wr_count - w0), 64'(8));
    check("sprite_first_wr_latency", 64'(first_wr_cyc - last_pop_cyc), 64'(4));
    check("sprite_idle_latency", 64'(idle_rise_cyc - last_pop_cyc), 64'(11));

    // Zero-width op followed by a fill
    w0 = wr_count; p0 = pops;
    push_op(mk_op(50, 50, 0, 5, 1'b1, 1'b0, 0, 1'b0));
    push_op(mk_op(1, 1, 2, 1, 1'b0, 1'b0, 0, 1'b0));
    wait_done("zero_then_fill", 200);
    check("zero_pops", 64'(pops - p0), 64'(2));
    check("zero_writes", 64'(wr_count - w0), 64'(2));

    // Single transparent texel (ROM[1] = 2'b01)
    w0 = wr_count;
    push_op(mk_op(7, 7, 1, 1, 1'b0, 1'b1, 1, 1'b0));
    wait_done("transp", 200);
`ifdef GPU_SPRITE_TRANSPARENCY_EN
    check("transp_writes", 64'(wr_count - w0), 64'(0));
`else
    check("transp_writes", 64'(wr_count - w0), 64'(1));
`endif

    // ce toggling during a fill, then reset mid-fill
    push_op(mk_op(100, 200, 20, 2, 1'b1, 1'b0, 0, 1'b0));
    for (int i = 0; i < 16; i++) begin
      ce = (i % 2 == 1);
      tick();
    end
    ce  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_wr.delete();
    @(negedge clk);
    check("post_rst_fb_wr_en", 64'(fb_wr_en), 64'(0));
    check("post_rst_op_rd_en", 64'(op_rd_en), 64'(0));
    check("post_rst_idle", 64'(idle), 64'(op_empty));
    check("post_rst_idle_high", 64'(idle), 64'(1));
    tick();
    w0 = wr_count;
    push_op(mk_op(0, 0, 2, 2, 1'b1, 1'b0, 0, 1'b0));
    wait_done("after_rst", 200);
    check("after_rst_writes", 64'(wr_count - w0), 64'(4));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
